serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller that time-shares one single-bit full-adder cell across a WIDTH-bit operand pair. It captures the operands on a start pulse, steps the full-adder through bit 0 to bit WIDTH-1 with a registered carry, and reports the result with a done pulse. It is used where area matters more than latency, for example partial-product accumulation in multiplier datapaths.

---
 rtl/serial_add_ctrl_pkg.sv | 15 +
 rtl/serial_add_ctrl_fa.sv | 14 +
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding and the operand width default and legal bounds.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 32;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell; purely combinational, time-shared by the
// serial controller across all operand bits.
module serial_add_ctrl_fa (
    input  logic i1,
    input  logic i2,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = i1 ^ i2 ^ Cin;
    assign Cout = (i1 & i2) | (i1 & Cin) | (i2 & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: captures operands on start, walks one
// full-adder cell LSB-first through WIDTH cycles, then pulses done.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of legal range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    serial_add_ctrl_fa u_fa (
        .i1   (a_sr[0]),
        .i2   (b_sr[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // NOTE: every register here is updated with <= so that all of them see
    // the pre-edge values of a_sr/b_sr/carry; blocking '=' would let the
    // shift happen before the cell's outputs are consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1, so invert B and seed carry with 1.
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized
// back-to-back operations checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered just after a falling edge; start is driven for cycle 0 and the
    // task returns after cycle W+2, so a following call is back-to-back.
    // Start is re-pulsed with junk operands in cycles p1/p2 (0 = none).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                         input logic ts, input logic tc,
                         input int p1, input int p2, input string name);
        logic [W:0]   full;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_busy;
        logic         exp_done;
        if (ts) begin
            exp_sum  = ta - tb_op;
            exp_cout = (ta >= tb_op);
        end else begin
            full     = {1'b0, ta} + {1'b0, tb_op} + {{W{1'b0}}, tc};
            exp_sum  = full[W-1:0];
            exp_cout = full[W];
        end
        a = ta; b = tb_op; sub = ts; cin = tc; start = 1'b1;
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk);
            exp_busy = (c <= W);
            exp_done = (c == W + 1);
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy@cycle%0d: got %b expected %b", name, c, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done@cycle%0d: got %b expected %b", name, c, done, exp_done);
            end
            if (c >= W + 1) begin
                checks++;
                if (sum !== exp_sum) begin
                    errors++;
                    $display("FAIL %s sum@cycle%0d: got %h expected %h", name, c, sum, exp_sum);
                end
                checks++;
                if (cout !== exp_cout) begin
                    errors++;
                    $display("FAIL %s cout@cycle%0d: got %b expected %b", name, c, cout, exp_cout);
                end
            end
            start = (c == p1 || c == p2) && (c < W + 2);
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, sum, cout} !== '0) begin
                errors++;
                $display("FAIL reset idle@%0d: got busy=%b done=%b sum=%h cout=%b expected all 0",
                         c, busy, done, sum, cout);
            end
        end
    endtask

    task automatic test_basic();
        do_op(8'h3C, 8'h0F, 1'b0, 1'b1, 0, 0, "add_basic");
        do_op(8'h05, 8'h07, 1'b1, 1'b0, 0, 0, "sub_borrow");
        do_op(8'h07, 8'h05, 1'b1, 1'b1, 0, 0, "sub_noborrow");
        do_op(8'h00, 8'h00, 1'b1, 1'b0, 0, 0, "sub_zero");
        do_op(8'hFF, 8'hFF, 1'b0, 1'b1, 0, 0, "add_max");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, "add_overflow");
    endtask

    task automatic test_reset_mid();
        a = 8'hFF; b = 8'h00; sub = 1'b0; cin = 1'b0; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, sum, cout} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy, done, sum, cout);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid quiet@%0d: got busy=%b done=%b expected 0 0", c, busy, done);
            end
        end
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 0, "after_reset");
    endtask

    task automatic test_ignored_start();
        do_op(8'h3C, 8'h0F, 1'b0, 1'b1, 3, 9, "ignored_start");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0, 0, "random");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
